dma_bus_arbiter: RTL and testbench
==================================

# dma_bus_arbiter

Sequential owner of the shared data bus. It takes DMA requests from IO1 and IO2 and negotiates bus ownership with the processor through a HOLD/HLDA handshake. It then sequences bounded two-cycle-per-word transfers between the granted IO device and memory, producing the one-hot bus drive enables and read/write strobes. It replaces the combinational priority decode for bus drivers, and sits between the IO devices, processor, memory and DMA address logic.

## Interface
- BURST_LEN, 4: maximum words transferred per grant (≥1).
- CNT_W, 3: word-counter width; must satisfy 2^CNT_W ≥ BURST_LEN.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- io1_req, io2_req  in  1  DMA request from IO1/IO2, level, held until acked transfers complete.
- io1_dir, io2_dir  in  1  transfer direction: 0 = IO→memory, 1 = memory→IO.
- hlda  in  1  processor hold acknowledge.
- hold  out  1  hold request to processor.
- io1_ack, io2_ack  out  1  DMA acknowledge, high in ADDR/DATA for the granted channel.
- proc_drv, io1_drv, io2_drv, mem_drv, dma_drv  out  1  bus drive enables, at most one high.
- mem_rd, mem_wr, io_rd, io_wr  out  1  transfer strobes, DATA state only.
- busy  out  1  high in every state except CPU.

## Operation
- States: CPU, HOLD_WAIT, ADDR, DATA, RELEASE. All outputs are decoded from registered state plus latched channel/dir, so there are no combinational paths from inputs to outputs.
- CPU: proc_drv=1, all else 0.
  - If any req is high, latch the channel and its dir, then go to HOLD_WAIT.
  - Both requesting: round-robin. The channel not served last wins. The pointer resets to favour IO1.
- HOLD_WAIT: hold=1, proc_drv=1.
  - hlda=1: go to ADDR and clear the word counter.
  - Latched req low before hlda: go to RELEASE with no transfer.
- ADDR: hold=1, dma_drv=1, ack for the latched channel. Go to DATA.
- DATA: hold=1, ack high.
  - dir=0: ioX_drv=1, io_rd=1, mem_wr=1.
  - dir=1: mem_drv=1, mem_rd=1, io_wr=1.
  - Counter increments.
  - Go to RELEASE if the counter reaches BURST_LEN−1 or the latched req is low; else go to ADDR.
- RELEASE: hold=0, all drivers 0, acks 0. Stay until hlda=0, then go to CPU.
- Round-robin pointer updates to the served channel on HOLD_WAIT→ADDR only. Aborted requests do not consume a turn.
- Channel and dir are constant for the whole grant. dir changes mid-grant are ignored.
- Requests from the other channel during a grant are ignored until CPU. CPU always lasts ≥1 cycle between grants, so the processor regains the bus.
- hlda sampled low in ADDR or DATA (protocol violation): next state RELEASE.
  - A DATA cycle already in progress completes its strobes and is counted.
  - An ADDR cycle is not counted.
- rst_n low at any edge: state=CPU, counter=0, pointer=IO1, latches cleared. This applies mid-transfer, and strobes drop on that edge.

## Timing
- Reset values: proc_drv=1. hold, busy, acks, other drivers and strobes all 0.
- req high sampled at edge N (in CPU): hold=1 from N+1.
- hlda high sampled at edge M (in HOLD_WAIT): ADDR from M+1, DATA from M+2.
- Throughput: one word per 2 cycles. A full burst is 2·BURST_LEN cycles of ack.
- hold deasserts the cycle after the last DATA. proc_drv reasserts one cycle after hlda is sampled low.
- Minimum request-to-first-strobe: 3 cycles plus processor hlda latency.
- Word counter is CNT_W bits and never wraps within a grant.

## Test plan
- Reset: hold rst_n low 2 cycles mid-DATA → next cycle proc_drv=1, hold=0, all strobes/acks 0, busy=0.
- Single IO1 burst:
  - Stimulus: io1_req=1, io1_dir=0, hlda returned 2 cycles after hold, BURST_LEN=4.
  - Response: exactly 4 DATA cycles with io1_drv=io_rd=mem_wr=1, io1_ack high 8 cycles, then hold=0.
- Round-robin: io1_req and io2_req both held high continuously → grants alternate IO1, IO2, IO1, with ≥1 CPU cycle (proc_drv=1) between them.
- Early stop: io2_req, dir=1, drops after the 2nd DATA → exactly 2 words (mem_drv=mem_rd=io_wr=1), then RELEASE.
- Abort: io1_req drops while in HOLD_WAIT → RELEASE, no strobes. The next simultaneous request still grants IO1 first (pointer unchanged).
- hlda violation: hlda drops during ADDR of word 3 → no 3rd-word strobes, immediate RELEASE, CPU once hlda is low.

Source files
------------

// File: rtl/dma_bus_arbiter.sv
// Bus ownership sequencer for two DMA channels: negotiates HOLD/HLDA with the
// processor and runs bounded ADDR/DATA word transfers for the granted channel.
module dma_bus_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic io1_req,
  input  logic io2_req,
  input  logic io1_dir,
  input  logic io2_dir,
  input  logic hlda,
  output logic hold,
  output logic io1_ack,
  output logic io2_ack,
  output logic proc_drv,
  output logic io1_drv,
  output logic io2_drv,
  output logic mem_drv,
  output logic dma_drv,
  output logic mem_rd,
  output logic mem_wr,
  output logic io_rd,
  output logic io_wr,
  output logic busy
);

  typedef enum logic [2:0] {
    S_CPU,
    S_HOLD_WAIT,
    S_ADDR,
    S_DATA,
    S_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);

  state_t           state_q, state_d;
  logic             chan_q, chan_d;
  logic             dir_q, dir_d;
  logic             favour_q, favour_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             latchedReq;

  // chan 0 = IO1, 1 = IO2; favour names the channel that wins a tie next
  assign latchedReq = chan_q ? io2_req : io1_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_CPU;
      chan_q   <= 1'b0;
      dir_q    <= 1'b0;
      favour_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      dir_q    <= dir_d;
      favour_q <= favour_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    dir_d    = dir_q;
    favour_d = favour_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_CPU: begin
        if (io1_req || io2_req) begin
          chan_d  = (io1_req && io2_req) ? favour_q : io2_req;
          dir_d   = chan_d ? io2_dir : io1_dir;
          state_d = S_HOLD_WAIT;
        end
      end
      S_HOLD_WAIT: begin
        if (hlda) begin
          state_d  = S_ADDR;
          cnt_d    = '0;
          favour_d = ~chan_q;
        end else if (!latchedReq) begin
          state_d = S_RELEASE;
        end
      end
      S_ADDR: state_d = hlda ? S_DATA : S_RELEASE;
      S_DATA: begin
        // Saturate on the final word so the counter cannot wrap when 2^CNT_W == BURST_LEN
        if (cnt_q != LAST_WORD) cnt_d = cnt_q + CNT_W'(1);
        if (!hlda || (cnt_q == LAST_WORD) || !latchedReq) state_d = S_RELEASE;
        else                                               state_d = S_ADDR;
      end
      S_RELEASE: if (!hlda) state_d = S_CPU;
      default:   state_d = S_CPU;
    endcase
  end

  always_comb begin
    hold     = 1'b0;
    io1_ack  = 1'b0;
    io2_ack  = 1'b0;
    proc_drv = 1'b0;
    io1_drv  = 1'b0;
    io2_drv  = 1'b0;
    mem_drv  = 1'b0;
    dma_drv  = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    io_rd    = 1'b0;
    io_wr    = 1'b0;
    busy     = (state_q != S_CPU);
    case (state_q)
      S_CPU: proc_drv = 1'b1;
      S_HOLD_WAIT: begin
        hold     = 1'b1;
        proc_drv = 1'b1;
      end
      S_ADDR: begin
        hold    = 1'b1;
        dma_drv = 1'b1;
        io1_ack = ~chan_q;
        io2_ack = chan_q;
      end
      S_DATA: begin
        hold    = 1'b1;
        io1_ack = ~chan_q;
        io2_ack = chan_q;
        if (dir_q) begin
          mem_drv = 1'b1;
          mem_rd  = 1'b1;
          io_wr   = 1'b1;
        end else begin
          io1_drv = ~chan_q;
          io2_drv = chan_q;
          io_rd   = 1'b1;
          mem_wr  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scoreboard bench for dma_bus_arbiter: expected DATA-cycle output vectors are
// queued by the directed tests and popped by a monitor on every strobe cycle.
module tb_dma_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic io1_req = 1'b0, io2_req = 1'b0, io1_dir = 1'b0, io2_dir = 1'b0;
  logic hlda = 1'b0;
  logic hold, io1_ack, io2_ack, proc_drv, io1_drv, io2_drv, mem_drv, dma_drv;
  logic mem_rd, mem_wr, io_rd, io_wr, busy;

  always #5 clk = ~clk;

  dma_bus_arbiter #(.BURST_LEN(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .io1_req(io1_req), .io2_req(io2_req), .io1_dir(io1_dir), .io2_dir(io2_dir),
    .hlda(hlda), .hold(hold), .io1_ack(io1_ack), .io2_ack(io2_ack),
    .proc_drv(proc_drv), .io1_drv(io1_drv), .io2_drv(io2_drv), .mem_drv(mem_drv),
    .dma_drv(dma_drv), .mem_rd(mem_rd), .mem_wr(mem_wr), .io_rd(io_rd),
    .io_wr(io_wr), .busy(busy)
  );

  // Vector order: hold io1_ack io2_ack proc io1_drv io2_drv mem_drv dma_drv mem_rd mem_wr io_rd io_wr busy
  localparam logic [12:0] IDLE_VEC    = 13'b0_0_0_1_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] HW_VEC      = 13'b1_0_0_1_0_0_0_0_0_0_0_0_1;
  localparam logic [12:0] REL_VEC     = 13'b0_0_0_0_0_0_0_0_0_0_0_0_1;
  localparam logic [12:0] ADDR1_VEC   = 13'b1_1_0_0_0_0_0_1_0_0_0_0_1;
  localparam logic [12:0] W_IO1_IN    = 13'b1_1_0_0_1_0_0_0_0_1_1_0_1;
  localparam logic [12:0] W_IO1_OUT   = 13'b1_1_0_0_0_0_1_0_1_0_0_1_1;
  localparam logic [12:0] W_IO2_IN    = 13'b1_0_1_0_0_1_0_0_0_1_1_0_1;
  localparam logic [12:0] W_IO2_OUT   = 13'b1_0_1_0_0_0_1_0_1_0_0_1_1;

  logic [12:0] expQ[$];
  int checks = 0;
  int failures = 0;
  int ackCycles = 0;
  bit autoHlda = 1'b1;
  logic manualHlda = 1'b0;
  logic [1:0] holdHist = 2'b00;

  function automatic logic [12:0] outVec();
    return {hold, io1_ack, io2_ack, proc_drv, io1_drv, io2_drv, mem_drv, dma_drv,
            mem_rd, mem_wr, io_rd, io_wr, busy};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Processor model: hlda follows hold two cycles later unless driven by hand
  initial forever begin
    @(posedge clk);
    #1;
    if (autoHlda) begin
      holdHist = {holdHist[0], hold};
      hlda = holdHist[1];
    end else begin
      holdHist = 2'b00;
      hlda = manualHlda;
    end
  end

  // Monitor: every strobe cycle is one transferred word and must match the queue head
  always @(negedge clk) begin
    if (io1_ack || io2_ack) ackCycles++;
    if (mem_rd || mem_wr || io_rd || io_wr) begin
      if (expQ.size() == 0) checkOutput("unexpected_word", 32'(outVec()), 32'h0);
      else                  checkOutput("word", 32'(outVec()), 32'(expQ.pop_front()));
    end
  end

  task automatic applyStimulus(input logic r1, input logic d1, input logic r2, input logic d2);
    io1_req = r1;
    io1_dir = d1;
    io2_req = r2;
    io2_dir = d2;
  endtask

  task automatic pushWords(input logic [12:0] vec, input int n);
    for (int i = 0; i < n; i++) expQ.push_back(vec);
  endtask

  task automatic waitHold(input logic level, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (hold == level) seen = 1'b1;
    end
    if (!seen) checkOutput(name, 32'(hold), 32'(level));
  endtask

  task automatic waitIdle(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    if (!seen) checkOutput({name, "_timeout"}, 32'(busy), 32'h0);
    else       checkOutput(name, 32'(outVec()), 32'(IDLE_VEC));
  endtask

  task automatic waitStrobes(input int n, input string name);
    int seen = 0;
    for (int c = 0; c < 60 && seen < n; c++) begin
      @(negedge clk);
      if (mem_rd || mem_wr || io_rd || io_wr) seen++;
    end
    if (seen < n) checkOutput(name, 32'(seen), 32'(n));
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_state", 32'(outVec()), 32'(IDLE_VEC));

    // Full IO1 burst, IO to memory
    base = ackCycles;
    pushWords(W_IO1_IN, 4);
    applyStimulus(1, 0, 0, 0);
    @(negedge clk);
    checkOutput("burst_hold_wait", 32'(outVec()), 32'(HW_VEC));
    waitHold(0, "burst_hold_drop");
    checkOutput("burst_release", 32'(outVec()), 32'(REL_VEC));
    applyStimulus(0, 0, 0, 0);
    waitIdle("burst_idle");
    checkOutput("burst_ack_cycles", 32'(ackCycles - base), 32'd8);
    checkOutput("burst_words_left", 32'(expQ.size()), 32'd0);

    // IO2 memory-to-IO, request withdrawn during the second word
    base = ackCycles;
    pushWords(W_IO2_OUT, 2);
    applyStimulus(0, 0, 1, 1);
    waitStrobes(2, "early_strobes");
    applyStimulus(0, 0, 0, 1);
    @(negedge clk);
    checkOutput("early_release", 32'(outVec()), 32'(REL_VEC));
    waitIdle("early_idle");
    checkOutput("early_ack_cycles", 32'(ackCycles - base), 32'd4);
    checkOutput("early_words_left", 32'(expQ.size()), 32'd0);

    // IO1 withdraws before hlda arrives: no transfer, turn not consumed
    applyStimulus(1, 0, 0, 0);
    @(negedge clk);
    checkOutput("abort_hold_wait", 32'(outVec()), 32'(HW_VEC));
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("abort_release", 32'(outVec()), 32'(REL_VEC));
    waitIdle("abort_idle");

    // Both channels request continuously: IO1, IO2, IO1
    base = ackCycles;
    pushWords(W_IO1_IN, 4);
    pushWords(W_IO2_IN, 4);
    pushWords(W_IO1_IN, 4);
    applyStimulus(1, 0, 1, 0);
    for (int g = 0; g < 3; g++) begin
      waitHold(0, "rr_hold_drop");
      if (g == 2) applyStimulus(0, 0, 0, 0);
      waitIdle("rr_cpu_between");
    end
    checkOutput("rr_ack_cycles", 32'(ackCycles - base), 32'd24);
    checkOutput("rr_words_left", 32'(expQ.size()), 32'd0);

    // hlda withdrawn at the start of the third ADDR cycle
    base = ackCycles;
    autoHlda = 1'b0;
    manualHlda = 1'b0;
    pushWords(W_IO1_OUT, 2);
    applyStimulus(1, 1, 0, 0);
    waitHold(1, "viol_hold_rise");
    manualHlda = 1'b1;
    waitStrobes(2, "viol_strobes");
    manualHlda = 1'b0;
    @(negedge clk);
    checkOutput("viol_addr3", 32'(outVec()), 32'(ADDR1_VEC));
    applyStimulus(0, 1, 0, 0);
    @(negedge clk);
    checkOutput("viol_release", 32'(outVec()), 32'(REL_VEC));
    @(negedge clk);
    checkOutput("viol_cpu", 32'(outVec()), 32'(IDLE_VEC));
    checkOutput("viol_ack_cycles", 32'(ackCycles - base), 32'd5);
    checkOutput("viol_words_left", 32'(expQ.size()), 32'd0);
    autoHlda = 1'b1;
    repeat (3) @(negedge clk);

    // Reset asserted for two cycles in the middle of the first DATA word
    pushWords(W_IO1_IN, 1);
    applyStimulus(1, 0, 0, 0);
    waitStrobes(1, "rst_strobes");
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_mid_data", 32'(outVec()), 32'(IDLE_VEC));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_after", 32'(outVec()), 32'(IDLE_VEC));
    repeat (4) @(negedge clk);
    checkOutput("rst_stays_idle", 32'(outVec()), 32'(IDLE_VEC));
    checkOutput("words_outstanding", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
